// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_pkg
// Description : Shared types and constants for the serial pattern generator
//               and its companion sequence detector.
// Revision    : 1.0
// ============================================================================
package seq_pkg;

    localparam int SEQ_WIDTH = 8;
    localparam int SEQ_CNT_W = $clog2(SEQ_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_PAR  = 2'd2,
        ST_GAP  = 2'd3
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/seq_shift.sv
`default_nettype none
// ============================================================================
// Module      : seq_shift
// Description : Loadable MSB-first shift register with bit counter. Keeps the
//               captured pattern for frame repeats. Parity output exists only
//               when SEQ_GEN_PARITY_EN is defined.
// Revision    : 1.0
// ============================================================================
module seq_shift
    import seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             restart,
    input  logic             shift,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic             first_bit,
    output logic             next_bit,
    output logic             last,
`ifdef SEQ_GEN_PARITY_EN
    output logic             parity,
`endif
    output logic [CW-1:0]    cnt
);

    logic [WIDTH-1:0] pat_q, pat_d;
    // Holds only the bits still to come; the bit on the line lives in the top.
    logic [WIDTH-2:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        pat_d = pat_q;
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (load) begin
            pat_d = din;
            sh_d  = din[WIDTH-2:0];
            cnt_d = '0;
        end else if (restart) begin
            sh_d  = pat_q[WIDTH-2:0];
            cnt_d = '0;
        end else if (shift) begin
            sh_d  = {sh_q[WIDTH-3:0], 1'b0};
            cnt_d = cnt_q + CW'(1);
        end else if (clear) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pat_q <= '0;
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            pat_q <= pat_d;
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

    assign first_bit = pat_q[WIDTH-1];
    assign next_bit  = sh_q[WIDTH-2];
    assign last      = (cnt_q == CW'(WIDTH - 1));
    assign cnt       = cnt_q;
`ifdef SEQ_GEN_PARITY_EN
    assign parity    = ^pat_q;
`endif

endmodule
`default_nettype wire

// File: rtl/seq_gen.sv
`default_nettype none
// ============================================================================
// Module      : seq_gen
// Description : Serial pattern generator. Shifts a captured pattern out MSB
//               first, rpt+1 frames with gap idle cycles between them.
//               Define SEQ_GEN_PARITY_EN to append an even-parity bit.
// Revision    : 1.0
// ============================================================================
module seq_gen
    import seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       start,
    input  logic [WIDTH-1:0]           setd,
    input  logic [3:0]                 rpt,
    input  logic [3:0]                 gap,
    output logic                       ds,
    output logic                       dv,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(WIDTH+1)-1:0] c
);

    seq_state_e state_q, state_d;
    logic [3:0] rpt_q, rpt_d;
    logic [3:0] gap_q, gap_d;
    logic [3:0] gcnt_q, gcnt_d;
    logic       ds_q, ds_d;
    logic       dv_q, dv_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic load, restart, shift, clear, frame_end;
    logic first_bit, next_bit, last;
`ifdef SEQ_GEN_PARITY_EN
    logic parity;
`endif

    seq_shift #(.WIDTH(WIDTH)) u_shift (
        .clk       (clk),
        .clr       (clr),
        .load      (load),
        .restart   (restart),
        .shift     (shift),
        .clear     (clear),
        .din       (setd),
        .first_bit (first_bit),
        .next_bit  (next_bit),
        .last      (last),
`ifdef SEQ_GEN_PARITY_EN
        .parity    (parity),
`endif
        .cnt       (c)
    );

    always_comb begin
        state_d   = state_q;
        rpt_d     = rpt_q;
        gap_d     = gap_q;
        gcnt_d    = gcnt_q;
        ds_d      = 1'b0;
        dv_d      = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        load      = 1'b0;
        restart   = 1'b0;
        shift     = 1'b0;
        clear     = 1'b0;
        frame_end = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    rpt_d   = rpt;
                    gap_d   = gap;
                    ds_d    = setd[WIDTH-1];
                    dv_d    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!last) begin
                    shift = 1'b1;
                    ds_d  = next_bit;
                    dv_d  = 1'b1;
                end else begin
`ifdef SEQ_GEN_PARITY_EN
                    shift   = 1'b1;
                    ds_d    = parity;
                    dv_d    = 1'b1;
                    state_d = ST_PAR;
`else
                    frame_end = 1'b1;
`endif
                end
            end
`ifdef SEQ_GEN_PARITY_EN
            ST_PAR: begin
                frame_end = 1'b1;
            end
`endif
            ST_GAP: begin
                if (gcnt_q == 4'd1) begin
                    restart = 1'b1;
                    ds_d    = first_bit;
                    dv_d    = 1'b1;
                    state_d = ST_SEND;
                end else begin
                    gcnt_d = gcnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Shared frame-end handling: repeat (with or without gap) or finish.
        if (frame_end) begin
            if (rpt_q != 4'd0) begin
                rpt_d = rpt_q - 4'd1;
                if (gap_q != 4'd0) begin
                    gcnt_d  = gap_q;
                    clear   = 1'b1;
                    state_d = ST_GAP;
                end else begin
                    restart = 1'b1;
                    ds_d    = first_bit;
                    dv_d    = 1'b1;
                    state_d = ST_SEND;
                end
            end else begin
                clear   = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            rpt_q   <= 4'd0;
            gap_q   <= 4'd0;
            gcnt_q  <= 4'd0;
            ds_q    <= 1'b0;
            dv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rpt_q   <= rpt_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            ds_q    <= ds_d;
            dv_q    <= dv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ds   = ds_q;
    assign dv   = dv_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_gen
// Description : Directed self-checking bench for seq_gen, with a reference
//               sequence detector on the serial output.
// Revision    : 1.0
// ============================================================================
module tb_seq_gen;
    import seq_pkg::*;

    localparam int W  = SEQ_WIDTH;
    localparam int CW = SEQ_CNT_W;
`ifdef SEQ_GEN_PARITY_EN
    localparam int F = W + 1;
`else
    localparam int F = W;
`endif

    logic          clk = 1'b0;
    logic          clr;
    logic          start;
    logic [W-1:0]  setd;
    logic [3:0]    rpt;
    logic [3:0]    gap;
    logic          ds, dv, busy, done;
    logic [CW-1:0] c;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] stream;
    logic        par_seen;

    logic [W-1:0] det_pat;
    logic [W-1:0] det_hist;
    logic         dc;

    seq_gen #(.WIDTH(W)) dut (
        .clk   (clk),
        .clr   (clr),
        .start (start),
        .setd  (setd),
        .rpt   (rpt),
        .gap   (gap),
        .ds    (ds),
        .dv    (dv),
        .busy  (busy),
        .done  (done),
        .c     (c)
    );

    always #5 clk = ~clk;

    // Reference detector: flags when the last W samples of ds equal det_pat.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            det_hist <= '0;
            dc       <= 1'b0;
        end else begin
            det_hist <= {det_hist[W-2:0], ds};
            dc       <= ({det_hist[W-2:0], ds} == det_pat);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic a, input logic b, input logic e,
                                         input logic d, input logic [CW-1:0] cc);
        return 32'({a, b, e, d, cc});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_burst(input string name, input logic [W-1:0] pat, input logic [3:0] r,
                             input logic [3:0] g, input bit hold, input bit scramble,
                             input bit det);
        logic eb;
        setd   = pat;
        rpt    = r;
        gap    = g;
        start  = 1'b1;
        stream = '0;
        tick();
        if (!hold) start = 1'b0;
        for (int f = 0; f <= int'(r); f++) begin
            for (int b = 0; b < F; b++) begin
                eb = (b == W) ? ^pat : pat[W-1-b];
                if (scramble) begin
                    setd  = '0;
                    rpt   = 4'd0;
                    gap   = 4'd0;
                    start = b[0];
                end
                check($sformatf("%s f%0d b%0d", name, f, b),
                      pack(ds, dv, busy, done, c), pack(eb, 1'b1, 1'b1, 1'b0, CW'(b)));
                if (det) check($sformatf("%s dc b%0d", name, b), 32'(dc), 32'd0);
                stream = {stream[30:0], ds};
                if (b == W) par_seen = ds;
                tick();
            end
            if (f < int'(r)) begin
                for (int i = 0; i < int'(g); i++) begin
                    if (scramble) start = 1'b1;
                    check($sformatf("%s gap f%0d g%0d", name, f, i),
                          pack(ds, dv, busy, done, c), pack(1'b0, 1'b0, 1'b1, 1'b0, '0));
                    stream = {stream[30:0], ds};
                    tick();
                end
            end
        end
        start = hold;
        check($sformatf("%s done", name), pack(ds, dv, busy, done, c),
              pack(1'b0, 1'b0, 1'b0, 1'b1, '0));
        if (det) check($sformatf("%s dc_hit", name), 32'(dc), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        det_pat = W'('hA5);
        par_seen = 1'b0;
        clr   = 1'b1;
        start = 1'b0;
        setd  = '0;
        rpt   = 4'd0;
        gap   = 4'd0;
        repeat (2) tick();
        check("reset", pack(ds, dv, busy, done, c), 32'd0);
        clr = 1'b0;
        tick();
        check("idle", pack(ds, dv, busy, done, c), 32'd0);

        // Single frame
        run_burst("b4", W'('hB4), 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
`ifndef SEQ_GEN_PARITY_EN
        check("b4 stream", 32'(stream[7:0]), 32'hB4);
`endif
        tick();
        check("b4 after", pack(ds, dv, busy, done, c), 32'd0);

        // Repeats with idle gaps
        run_burst("r81", W'('h81), 4'd2, 4'd3, 1'b0, 1'b0, 1'b0);
`ifndef SEQ_GEN_PARITY_EN
        check("r81 stream", 32'(stream[29:0]), 32'(30'b100000010001000000100010000001));
`endif
        tick();

        // Back-to-back, inputs disturbed and start pulsed mid-burst
        run_burst("f0", W'('hF0), 4'd1, 4'd0, 1'b0, 1'b1, 1'b0);
`ifndef SEQ_GEN_PARITY_EN
        check("f0 stream", 32'(stream[15:0]), 32'hF0F0);
`endif
        tick();
        check("f0 after", pack(ds, dv, busy, done, c), 32'd0);

        // Start held: second burst follows the done cycle directly
        run_burst("hold1", W'('h3C), 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        run_burst("hold2", W'('h5A), 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check("hold after", pack(ds, dv, busy, done, c), 32'd0);

        // Asynchronous clear at bit 3
        setd  = W'('hA5);
        rpt   = 4'd3;
        gap   = 4'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("pre_clr c", 32'(c), 32'd3);
        #2 clr = 1'b1;
        #1;
        check("clr async", pack(ds, dv, busy, done, c), 32'd0);
        repeat (2) tick();
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_clr %0d", i), pack(ds, dv, busy, done, c), 32'd0);
        end
        run_burst("after_clr", W'('h96), 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();

`ifndef SEQ_GEN_PARITY_EN
        run_burst("loop", W'('hA5), 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        tick();
        check("loop dc drop", 32'(dc), 32'd0);
`else
        run_burst("par", W'('hA5), 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        check("par a5", 32'(par_seen), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
